// File: rtl/div_row_normalizer_if.sv
// Bundle of every handshake and data signal between the row normalizer,
// its upstream producer, its downstream consumer and the integer divider.
// The master modport is the normalizer's own view; slave is the environment.
interface div_row_normalizer_if #(
   parameter int VEC_LEN = 16,
   parameter int DIV_W   = 18,
   parameter int QUOT_W  = 8
);

   // Upstream row handshake
   logic                      vld_in;
   logic                      rdy_out;
   logic [VEC_LEN*DIV_W-1:0]  num_vec_in;
   logic [DIV_W-1:0]          den_in;

   // Downstream normalized row handshake
   logic                      vld_out;
   logic                      rdy_in;
   logic [VEC_LEN*QUOT_W-1:0] quot_vec_out;

   // Divider request channel
   logic                      div_vld_out;
   logic                      div_rdy_in;
   logic [DIV_W-1:0]          div_num_out;
   logic [DIV_W-1:0]          div_den_out;

   // Divider response channel
   logic                      div_vld_in;
   logic                      div_rdy_out;
   logic [QUOT_W-1:0]         div_quot_in;

   modport master (
      input  vld_in,
      input  num_vec_in,
      input  den_in,
      output rdy_out,
      output vld_out,
      input  rdy_in,
      output quot_vec_out,
      output div_vld_out,
      input  div_rdy_in,
      output div_num_out,
      output div_den_out,
      input  div_vld_in,
      output div_rdy_out,
      input  div_quot_in
   );

   modport slave (
      output vld_in,
      output num_vec_in,
      output den_in,
      input  rdy_out,
      input  vld_out,
      output rdy_in,
      input  quot_vec_out,
      input  div_vld_out,
      output div_rdy_in,
      input  div_num_out,
      input  div_den_out,
      output div_vld_in,
      input  div_rdy_out,
      output div_quot_in
   );

endinterface

// File: rtl/div_row_normalizer.sv
// FlashAttention final-normalization sequencer.
// Latches one accumulated output row plus its row-sum denominator, streams
// each (numerator, denominator) pair through the shared integer divider,
// gathers the Q0.7 quotients back in lane order and presents the finished
// row downstream. A zero denominator skips the divider entirely and yields
// a sign-saturated row.
module div_row_normalizer #(
   parameter int VEC_LEN = 16,
   parameter int DIV_W   = 18,
   parameter int QUOT_W  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   div_row_normalizer_if.master bus
);

   localparam int CNT_W = $clog2(VEC_LEN + 1);
   localparam int IDX_W = $clog2(VEC_LEN);

   localparam logic [CNT_W-1:0]  LEN_C   = CNT_W'(VEC_LEN);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [QUOT_W-1:0] Q_MAX   = {1'b0, {(QUOT_W-1){1'b1}}};
   localparam logic [QUOT_W-1:0] Q_MIN   = {1'b1, {(QUOT_W-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAT,
      ST_BUSY,
      ST_OUT
   } state_e;

   state_e            state_q,     state_d;
   logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]  recv_cnt_q,  recv_cnt_d;
   logic [DIV_W-1:0]  den_buf_q,   den_buf_d;
   logic [DIV_W-1:0]  num_buf_q  [VEC_LEN];
   logic [DIV_W-1:0]  num_buf_d  [VEC_LEN];
   logic [QUOT_W-1:0] quot_buf_q [VEC_LEN];
   logic [QUOT_W-1:0] quot_buf_d [VEC_LEN];

   logic              busy;
   logic              row_rdy;
   logic              row_accept;
   logic              issue_pending;
   logic              recv_pending;
   logic              issue_fire;
   logic              recv_fire;
   logic [IDX_W-1:0]  issue_idx;
   logic [IDX_W-1:0]  recv_idx;

   // Handshake qualifiers derived from the registered state and counters
   always_comb begin
      busy          = (state_q == ST_BUSY);
      row_rdy       = (state_q == ST_IDLE) & ~reset;
      row_accept    = bus.vld_in & row_rdy;
      issue_pending = busy & (issue_cnt_q < LEN_C);
      recv_pending  = busy & (recv_cnt_q < LEN_C);
      issue_fire    = issue_pending & bus.div_rdy_in;
      recv_fire     = recv_pending & bus.div_vld_in;
      issue_idx     = issue_cnt_q[IDX_W-1:0];
      recv_idx      = recv_cnt_q[IDX_W-1:0];
   end

   // Next-state, counter and buffer update for the row sequencer
   always_comb begin
      state_d     = state_q;
      issue_cnt_d = issue_cnt_q;
      recv_cnt_d  = recv_cnt_q;
      den_buf_d   = den_buf_q;
      num_buf_d   = num_buf_q;
      quot_buf_d  = quot_buf_q;

      case (state_q)
         ST_IDLE: begin
            if (row_accept) begin
               for (int i = 0; i < VEC_LEN; i++) begin
                  num_buf_d[i]  = bus.num_vec_in[i*DIV_W +: DIV_W];
                  quot_buf_d[i] = '0;
               end
               den_buf_d   = bus.den_in;
               issue_cnt_d = '0;
               recv_cnt_d  = '0;
               state_d     = (bus.den_in == '0) ? ST_SAT : ST_BUSY;
            end
         end

         ST_SAT: begin
            for (int i = 0; i < VEC_LEN; i++) begin
               quot_buf_d[i] = num_buf_q[i][DIV_W-1] ? Q_MIN : Q_MAX;
            end
            state_d = ST_OUT;
         end

         ST_BUSY: begin
            if (issue_fire) begin
               issue_cnt_d = issue_cnt_q + CNT_ONE;
            end
            if (recv_fire) begin
               quot_buf_d[recv_idx] = bus.div_quot_in;
               recv_cnt_d           = recv_cnt_q + CNT_ONE;
            end
            if (recv_cnt_q == LEN_C) begin
               state_d = ST_OUT;
            end
         end

         ST_OUT: begin
            if (bus.rdy_in) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and row buffers; a reset drops any partial row
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         issue_cnt_q <= '0;
         recv_cnt_q  <= '0;
         den_buf_q   <= '0;
         for (int i = 0; i < VEC_LEN; i++) begin
            num_buf_q[i]  <= '0;
            quot_buf_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         issue_cnt_q <= issue_cnt_d;
         recv_cnt_q  <= recv_cnt_d;
         den_buf_q   <= den_buf_d;
         for (int i = 0; i < VEC_LEN; i++) begin
            num_buf_q[i]  <= num_buf_d[i];
            quot_buf_q[i] <= quot_buf_d[i];
         end
      end
   end

   // Output decode; all drives come straight from flops except the
   // upstream ready, which is also forced low while reset is held
   always_comb begin
      bus.rdy_out      = row_rdy;
      bus.vld_out      = (state_q == ST_OUT);
      bus.quot_vec_out = '0;
      for (int i = 0; i < VEC_LEN; i++) begin
         bus.quot_vec_out[i*QUOT_W +: QUOT_W] = quot_buf_q[i];
      end
      bus.div_vld_out  = issue_pending;
      bus.div_num_out  = issue_pending ? num_buf_q[issue_idx] : '0;
      bus.div_den_out  = busy ? den_buf_q : '0;
      bus.div_rdy_out  = recv_pending;
   end

endmodule
